// File: rtl/counter_scan_multi.sv
// Up/down event counter whose register doubles as CHAINS parallel scan chains.
// Adds parallel load, wrap/saturate, terminal count, sticky overflow and scan-group tracking.
module counter_scan_multi #(
  parameter int WIDTH    = 16,
  parameter int CHAINS   = 2,
  parameter int SATURATE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up_dn,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              scan_en,
  input  logic [CHAINS-1:0] scan_in,
  output logic [WIDTH-1:0]  count_out,
  output logic [CHAINS-1:0] scan_out,
  output logic              tc,
  output logic              ovf,
  output logic              shift_done,
  output logic              shift_abort
);

  localparam int L  = WIDTH / CHAINS;
  localparam int CW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic {FUNC, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    shift_cnt, shift_cnt_nxt;
  logic             done_nxt, abort_nxt;
  logic [WIDTH-1:0] count_nxt, shifted;
  logic             ovf_nxt;

  // Each chain shifts toward its own MSB; the MSB is the serial output.
  for (genvar k = 0; k < CHAINS; k++) begin : g_chain
    assign shifted[k*L +: L] = {count_out[k*L +: L-1], scan_in[k]};
    assign scan_out[k]       = count_out[k*L + L - 1];
  end

  assign tc = up_dn ? (&count_out) : ~(|count_out);

  // NOTE: every variable gets a default before any branch, so no latch can be inferred.
  always_comb begin
    count_nxt = count_out;
    ovf_nxt   = ovf;
    if (scan_en) begin
      count_nxt = shifted;
    end else if (load) begin
      count_nxt = load_val;
      ovf_nxt   = 1'b0;
    end else if (enable) begin
      if (up_dn) begin
        if (&count_out) begin
          ovf_nxt   = 1'b1;
          count_nxt = (SATURATE != 0) ? count_out : '0;
        end else begin
          count_nxt = count_out + WIDTH'(1);
        end
      end else begin
        if (~|count_out) begin
          ovf_nxt   = 1'b1;
          count_nxt = (SATURATE != 0) ? count_out : '1;
        end else begin
          count_nxt = count_out - WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_cnt_nxt = shift_cnt;
    done_nxt      = 1'b0;
    abort_nxt     = 1'b0;
    case (state)
      FUNC: begin
        if (scan_en) begin
          state_nxt     = SHIFT;
          shift_cnt_nxt = CW'(1);
        end
      end
      SHIFT: begin
        if (scan_en) begin
          if (shift_cnt == CW'(L-1)) begin
            done_nxt      = 1'b1;
            shift_cnt_nxt = '0;
          end else begin
            shift_cnt_nxt = shift_cnt + CW'(1);
          end
        end else begin
          abort_nxt     = (shift_cnt != '0);
          shift_cnt_nxt = '0;
          state_nxt     = FUNC;
        end
      end
      default: begin
        state_nxt     = FUNC;
        shift_cnt_nxt = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FUNC;
      shift_cnt   <= '0;
      count_out   <= '0;
      ovf         <= 1'b0;
      shift_done  <= 1'b0;
      shift_abort <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_cnt   <= shift_cnt_nxt;
      count_out   <= count_nxt;
      ovf         <= ovf_nxt;
      shift_done  <= done_nxt;
      shift_abort <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_counter_scan_multi.sv
// Bench for counter_scan_multi (WIDTH=8, CHAINS=2): wrapping and saturating instances
// driven in parallel and compared against an arithmetic reference model.
module tb_counter_scan_multi;

  localparam int W   = 8;
  localparam int C   = 2;
  localparam int L   = W / C;
  localparam logic [W-1:0] MAX = 8'hFF;

  logic         clk = 1'b0;
  logic         rst, enable, up_dn, load, scan_en;
  logic [W-1:0] load_val;
  logic [C-1:0] scan_in;

  logic [W-1:0] count_out, count_out_s;
  logic [C-1:0] scan_out, scan_out_s;
  logic         tc, ovf, shift_done, shift_abort;
  logic         tc_s, ovf_s, shift_done_s, shift_abort_s;

  int checks = 0;
  int errors = 0;

  // Reference model state (value after the most recent edge).
  logic [W-1:0] m_cnt, m_cnt_s;
  logic         m_ovf, m_ovf_s, m_done, m_abort;
  int           m_run;

  counter_scan_multi #(.WIDTH(W), .CHAINS(C), .SATURATE(0)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .scan_en(scan_en), .scan_in(scan_in),
    .count_out(count_out), .scan_out(scan_out), .tc(tc), .ovf(ovf),
    .shift_done(shift_done), .shift_abort(shift_abort)
  );

  counter_scan_multi #(.WIDTH(W), .CHAINS(C), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .load(load),
    .load_val(load_val), .scan_en(scan_en), .scan_in(scan_in),
    .count_out(count_out_s), .scan_out(scan_out_s), .tc(tc_s), .ovf(ovf_s),
    .shift_done(shift_done_s), .shift_abort(shift_abort_s)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] shift_val(logic [W-1:0] v, logic [C-1:0] sin);
    int res, chain;
    int mask = (1 << L) - 1;
    res = 0;
    for (int k = 0; k < C; k++) begin
      chain = (int'(v) >> (k * L)) & mask;
      chain = ((chain << 1) | int'(sin[k])) & mask;
      res   = res | (chain << (k * L));
    end
    return W'(res);
  endfunction

  task automatic model_reset();
    m_cnt = '0; m_cnt_s = '0; m_ovf = 1'b0; m_ovf_s = 1'b0;
    m_done = 1'b0; m_abort = 1'b0; m_run = 0;
  endtask

  task automatic model_update();
    m_done  = 1'b0;
    m_abort = 1'b0;
    if (scan_en) begin
      m_cnt   = shift_val(m_cnt, scan_in);
      m_cnt_s = shift_val(m_cnt_s, scan_in);
      m_run++;
      if (m_run % L == 0) m_done = 1'b1;
    end else begin
      if (m_run % L != 0) m_abort = 1'b1;
      m_run = 0;
      if (load) begin
        m_cnt = load_val; m_cnt_s = load_val; m_ovf = 1'b0; m_ovf_s = 1'b0;
      end else if (enable) begin
        if (up_dn) begin
          if (m_cnt == MAX) begin m_cnt = '0; m_ovf = 1'b1; end else m_cnt = m_cnt + 8'd1;
          if (m_cnt_s == MAX) m_ovf_s = 1'b1; else m_cnt_s = m_cnt_s + 8'd1;
        end else begin
          if (m_cnt == 8'd0) begin m_cnt = MAX; m_ovf = 1'b1; end else m_cnt = m_cnt - 8'd1;
          if (m_cnt_s == 8'd0) m_ovf_s = 1'b1; else m_cnt_s = m_cnt_s - 8'd1;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
    scan_en = 1'b0; scan_in = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count_out !== 8'h00) begin errors++; $display("FAIL reset_count: got=%h exp=00", count_out); end
    checks++; if ({ovf, shift_done, shift_abort} !== 3'b000) begin errors++; $display("FAIL reset_flags: got=%b exp=000", {ovf, shift_done, shift_abort}); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL reset_tc_down: got=%b exp=1", tc); end
    @(negedge clk);
    rst = 1'b0;
    load = 1'b1; load_val = 8'h05; tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b1; tick(); tick();
    checks++; if (count_out !== 8'h07) begin errors++; $display("FAIL count_from_05: got=%h exp=07", count_out); end
    scan_en = 1'b1; scan_in = 2'b11; tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (count_out !== 8'h00) begin errors++; $display("FAIL midcycle_reset_count: got=%h exp=00", count_out); end
    checks++; if ({ovf, shift_done, shift_abort} !== 3'b000) begin errors++; $display("FAIL midcycle_reset_flags: got=%b exp=000", {ovf, shift_done, shift_abort}); end
    model_reset();
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if ({count_out, shift_done, shift_abort} !== 10'h000) begin errors++; $display("FAIL reset_release: got count=%h done=%b abort=%b exp 00/0/0", count_out, shift_done, shift_abort); end
  endtask

  task automatic test_wrap_up();
    logic [W-1:0] exp_w [3];
    exp_w[0] = 8'hFF; exp_w[1] = 8'h00; exp_w[2] = 8'h01;
    idle();
    load = 1'b1; load_val = 8'hFE; tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count_out !== exp_w[i]) begin errors++; $display("FAIL wrap_up_%0d: got=%h exp=%h", i, count_out, exp_w[i]); end
      checks++; if (count_out_s !== 8'hFF) begin errors++; $display("FAIL sat_up_%0d: got=%h exp=ff", i, count_out_s); end
      if (i == 0) begin
        checks++; if (tc !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL wrap_up_tc: got tc=%b ovf=%b exp 1/0", tc, ovf); end
      end
    end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_up_ovf: got=%b exp=1", ovf); end
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL sat_up_ovf: got=%b exp=1", ovf_s); end
  endtask

  task automatic test_wrap_down();
    idle();
    load = 1'b1; load_val = 8'h01; tick();
    load = 1'b0; enable = 1'b1; up_dn = 1'b0; tick();
    checks++; if (count_out !== 8'h00 || tc !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL down_zero: got=%h tc=%b ovf=%b exp 00/1/0", count_out, tc, ovf); end
    tick();
    checks++; if (count_out !== 8'hFF || ovf !== 1'b1) begin errors++; $display("FAIL down_wrap: got=%h ovf=%b exp ff/1", count_out, ovf); end
    checks++; if (count_out_s !== 8'h00 || ovf_s !== 1'b1) begin errors++; $display("FAIL down_sat: got=%h ovf=%b exp 00/1", count_out_s, ovf_s); end
    enable = 1'b0; load = 1'b1; load_val = 8'h10; tick();
    checks++; if (count_out !== 8'h10 || ovf !== 1'b0 || ovf_s !== 1'b0) begin errors++; $display("FAIL load_clears_ovf: got=%h ovf=%b ovf_s=%b exp 10/0/0", count_out, ovf, ovf_s); end
  endtask

  task automatic test_scan_load();
    logic [3:0] s0, s1;
    s0 = 4'b1011; s1 = 4'b0001;
    idle();
    load = 1'b1; load_val = 8'h00; tick();
    load = 1'b0; scan_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      scan_in = {s1[3-i], s0[3-i]};
      tick();
      checks++; if (shift_done !== (i == 3) || shift_abort !== 1'b0) begin errors++; $display("FAIL scan_pulse_%0d: got done=%b abort=%b exp done=%b", i, shift_done, shift_abort, i == 3); end
    end
    checks++; if (count_out !== 8'h1B) begin errors++; $display("FAIL scan_value: got=%h exp=1b", count_out); end
    checks++; if (scan_out !== 2'b01) begin errors++; $display("FAIL scan_out: got=%b exp=01", scan_out); end
    scan_en = 1'b0; tick();
    checks++; if (shift_done !== 1'b0 || shift_abort !== 1'b0 || count_out !== 8'h1B) begin errors++; $display("FAIL scan_exit: got done=%b abort=%b count=%h exp 0/0/1b", shift_done, shift_abort, count_out); end
  endtask

  task automatic test_abort();
    idle();
    load = 1'b1; load_val = 8'h00; tick();
    load = 1'b0; scan_en = 1'b1; scan_in = 2'b00; tick(); tick();
    scan_en = 1'b0; enable = 1'b1; up_dn = 1'b1; tick();
    checks++; if (shift_abort !== 1'b1 || shift_done !== 1'b0 || count_out !== 8'h01) begin errors++; $display("FAIL abort_pulse: got abort=%b done=%b count=%h exp 1/0/01", shift_abort, shift_done, count_out); end
    tick();
    checks++; if (shift_abort !== 1'b0 || count_out !== 8'h02) begin errors++; $display("FAIL abort_one_cycle: got abort=%b count=%h exp 0/02", shift_abort, count_out); end
    enable = 1'b0; scan_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (shift_done !== (i == 3)) begin errors++; $display("FAIL abort_restart_%0d: got done=%b exp=%b", i, shift_done, i == 3); end
    end
    scan_en = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    int dones, aborts;
    dones = 0; aborts = 0;
    idle();
    scan_en = 1'b1; load = 1'b1; enable = 1'b1; up_dn = 1'b1; load_val = 8'hAA;
    for (int i = 0; i < 2 * L; i++) begin
      scan_in = C'($urandom);
      tick();
      dones  += int'(shift_done);
      aborts += int'(shift_abort);
      checks++; if (count_out !== m_cnt) begin errors++; $display("FAIL b2b_shift_%0d: got=%h exp=%h", i, count_out, m_cnt); end
    end
    checks++; if (dones !== 2 || aborts !== 0) begin errors++; $display("FAIL b2b_pulses: got done=%0d abort=%0d exp 2/0", dones, aborts); end
    idle(); tick();
    checks++; if (shift_abort !== 1'b0 || shift_done !== 1'b0) begin errors++; $display("FAIL b2b_exit: got done=%b abort=%b exp 0/0", shift_done, shift_abort); end
  endtask

  task automatic test_random();
    logic exp_tc;
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 3) != 0);
      up_dn    = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 9) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? 8'hFE : W'($urandom);
      if ($urandom_range(0, 5) == 0) scan_en = ~scan_en;
      scan_in  = C'($urandom);
      tick();
      exp_tc = up_dn ? (m_cnt == MAX) : (m_cnt == 8'h00);
      checks++; if (count_out !== m_cnt) begin errors++; $display("FAIL rand_count_%0d: got=%h exp=%h", i, count_out, m_cnt); end
      checks++; if (count_out_s !== m_cnt_s) begin errors++; $display("FAIL rand_count_sat_%0d: got=%h exp=%h", i, count_out_s, m_cnt_s); end
      checks++; if ({ovf, ovf_s} !== {m_ovf, m_ovf_s}) begin errors++; $display("FAIL rand_ovf_%0d: got=%b%b exp=%b%b", i, ovf, ovf_s, m_ovf, m_ovf_s); end
      checks++; if ({shift_done, shift_abort, shift_done_s, shift_abort_s} !== {m_done, m_abort, m_done, m_abort}) begin errors++; $display("FAIL rand_pulses_%0d: got=%b%b%b%b exp=%b%b", i, shift_done, shift_abort, shift_done_s, shift_abort_s, m_done, m_abort); end
      checks++; if (tc !== exp_tc) begin errors++; $display("FAIL rand_tc_%0d: got=%b exp=%b", i, tc, exp_tc); end
      checks++; if (scan_out !== {m_cnt[7], m_cnt[3]}) begin errors++; $display("FAIL rand_scan_out_%0d: got=%b exp=%b", i, scan_out, {m_cnt[7], m_cnt[3]}); end
    end
    idle(); tick();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_scan_load();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
